// File: rtl/writeback_arbiter.sv
// Round-robin merge of the RS and LSB result streams onto the single ROB writeback port.
// Optional WB_BYPASS_EN: an empty channel may offer its incoming result straight to the port.
module wb_fifo #(
  parameter int DEPTH_LOG = 2,
  parameter int W         = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         ready,
  output logic         empty
);
  localparam int DEPTH = 1 << DEPTH_LOG;

  logic [W-1:0]         mem [DEPTH];
  logic [DEPTH_LOG-1:0] rd_ptr, wr_ptr;
  logic [DEPTH_LOG:0]   cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (en) begin
      if (clr) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + DEPTH_LOG'(1);
        if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG'(1);
        case ({push, pop})
          2'b10:   cnt <= cnt + (DEPTH_LOG+1)'(1);
          2'b01:   cnt <= cnt - (DEPTH_LOG+1)'(1);
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (en && !clr && push) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign ready = (cnt != (DEPTH_LOG+1)'(DEPTH));
  assign empty = (cnt == '0);
endmodule

module writeback_arbiter #(
  parameter int FIFO_DEPTH_LOG = 2,
  parameter int ROB_WIDTH      = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush,
  input  logic                 rs_valid,
  input  logic [ROB_WIDTH-1:0] rs_rob_id,
  input  logic [31:0]          rs_data,
  output logic                 rs_ready,
  input  logic                 lsb_valid,
  input  logic [ROB_WIDTH-1:0] lsb_rob_id,
  input  logic [31:0]          lsb_data,
  output logic                 lsb_ready,
  output logic                 wb_valid,
  output logic [ROB_WIDTH-1:0] wb_rob_id,
  output logic [31:0]          wb_data
);
  localparam int NUM_LANES = 2;
  localparam int EW        = ROB_WIDTH + 32;

  typedef struct packed {
    logic [ROB_WIDTH-1:0] rob_id;
    logic [31:0]          data;
  } wb_ent_t;

  wb_ent_t [NUM_LANES-1:0] in_ent, head_ent, offer;
  logic    [NUM_LANES-1:0] in_vld, ready, empty, acc, cand, push, pop;
  logic                    last, win, any;
  logic                    live;

  assign live      = rdy_in && !flush;
  assign in_vld    = {lsb_valid, rs_valid};
  assign in_ent[0] = '{rob_id: rs_rob_id,  data: rs_data};
  assign in_ent[1] = '{rob_id: lsb_rob_id, data: lsb_data};
  assign acc       = in_vld & ready & {NUM_LANES{live}};

`ifdef WB_BYPASS_EN
  assign cand = ~empty | acc;
`else
  assign cand = ~empty;
`endif

  // Lane 0 = RS, lane 1 = LSB; on a tie the lane that did not win last goes.
  assign any = |cand;
  assign win = (&cand) ? ~last : cand[1];

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign offer[i] = empty[i] ? in_ent[i] : head_ent[i];
    assign pop[i]   = live && any && (win == 1'(i)) && !empty[i];
    // A bypass winner goes straight to wb_* and never lands in the FIFO.
    assign push[i]  = acc[i] && !(any && (win == 1'(i)) && empty[i]);

    wb_fifo #(.DEPTH_LOG(FIFO_DEPTH_LOG), .W(EW)) u_fifo (
      .clk   (clk_in),
      .rst_n (rst_in),
      .en    (rdy_in),
      .clr   (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (in_ent[i]),
      .head  (head_ent[i]),
      .ready (ready[i]),
      .empty (empty[i])
    );
  end

  assign rs_ready  = ready[0];
  assign lsb_ready = ready[1];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wb_valid  <= 1'b0;
      wb_rob_id <= '0;
      wb_data   <= '0;
      last      <= 1'b1;
    end else if (rdy_in) begin
      if (flush) begin
        wb_valid <= 1'b0;
        last     <= 1'b1;
      end else if (any) begin
        wb_valid  <= 1'b1;
        wb_rob_id <= offer[win].rob_id;
        wb_data   <= offer[win].data;
        last      <= win;
      end else begin
        wb_valid <= 1'b0;
      end
    end
  end
endmodule
